// File: rtl/instr_encoder_loader.sv
// Packs decoded-field instruction requests (R, I-ALU, LOAD, STORE, BRANCH) into RV32I words
// and streams them into instruction memory, one word per cycle, during a load session.
module instr_encoder_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_func3,
    input  logic              req_alt,
    input  logic [12:0]       req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [15:0]       count
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;
    logic              fill;
    logic [15:0]       count_n;
    logic              unused_imm0;

    // Branch offsets are always even, so imm[0] carries no information.
    assign unused_imm0 = req_imm[0];

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (req_type)
            3'd0: enc = {1'b0, req_alt, 5'b00000, req_rs2, req_rs1, req_func3, req_rd, OP_R};
            3'd1: enc = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_I};
            3'd2: enc = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_LOAD};
            3'd3: enc = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
            3'd4: enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                         req_imm[4:1], req_imm[11], OP_BRANCH};
            default: legal = 1'b0;
        endcase
    end

    // req_ready is only ever high in LOAD, so accept implies the LOAD state.
    assign accept  = req_valid && req_ready;
    assign fill    = accept && legal && (count == DEPTH_W - 16'd1);
    assign count_n = (accept && legal) ? count + 16'd1 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= BASE_ADDR;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b0;
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        req_ready <= 1'b1;
                        count     <= '0;
                        full      <= 1'b0;
                        err       <= 1'b0;
                        ptr       <= BASE_ADDR;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= enc;
                            mem_addr  <= ptr;
                            ptr       <= ptr + ADDR_W'(4);
                            count     <= count_n;
                        end else begin
                            err <= 1'b1;
                        end
                        if (fill) begin
                            full <= 1'b1;
                        end
                    end
                    if (accept && (req_last || fill)) begin
                        state     <= S_FLUSH;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= (count_n < DEPTH_W);
                    end
                end
                S_FLUSH: begin
                    state     <= S_DONE;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a field-level reference encoder predicts every
// memory write; monitors pop and compare whenever mem_we is seen.
module tb_instr_encoder_loader;

    localparam int unsigned DEPTH_A = 4;
    localparam logic [31:0] BASE_A  = 32'h0;
    localparam logic [31:0] BASE_B  = 32'h100;

    typedef struct {
        logic [2:0]  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic        alt;
        logic [12:0] imm;
        logic        last;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_b = 1'b1, start = 1'b0, req_valid = 1'b0;
    logic [2:0]  req_type = '0, req_func3 = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic        req_alt = 1'b0, req_last = 1'b0;
    logic [12:0] req_imm = '0;

    logic        ready_a, we_a, busy_a, done_a, full_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [15:0] count_a;
    logic        ready_b, we_b, busy_b, done_b, full_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [15:0] count_b;

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(BASE_A), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(ready_a),
        .req_type(req_type), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_func3(req_func3), .req_alt(req_alt), .req_imm(req_imm), .req_last(req_last),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .busy(busy_a), .done(done_a),
        .full(full_a), .err(err_a), .count(count_a)
    );

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(BASE_B), .DEPTH(256)) dut_b (
        .clk(clk), .rst(rst_b), .start(start), .req_valid(req_valid), .req_ready(ready_b),
        .req_type(req_type), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_func3(req_func3), .req_alt(req_alt), .req_imm(req_imm), .req_last(req_last),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b), .done(done_b),
        .full(full_b), .err(err_b), .count(count_b)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    wr_t q_a[$];
    wr_t q_b[$];
    int unsigned n_a, n_b;
    bit err_m, full_m, open_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: places each field at its RV32I bit position arithmetically.
    function automatic logic [31:0] model_word(input req_t r);
        logic [31:0] w;
        logic [31:0] imm;
        imm = 32'(r.imm);
        w = (32'(r.rs1) << 15) | (32'(r.func3) << 12);
        case (r.t)
            3'd0: w |= 32'h33 | (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.alt) << 30);
            3'd1: w |= 32'h13 | (32'(r.rd) << 7) | ((imm & 32'hFFF) << 20);
            3'd2: w |= 32'h03 | (32'(r.rd) << 7) | ((imm & 32'hFFF) << 20);
            3'd3: w |= 32'h23 | ((imm & 32'h1F) << 7) | (32'(r.rs2) << 20)
                       | (((imm >> 5) & 32'h7F) << 25);
            3'd4: w |= 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                       | (32'(r.rs2) << 20) | (((imm >> 5) & 32'h3F) << 25)
                       | (((imm >> 12) & 32'h1) << 31);
            default: w = '0;
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        if (we_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write_a: got addr 0x%08h data 0x%08h, expected no write", addr_a, wdata_a);
            end else begin
                wr_t e;
                e = q_a.pop_front();
                check("wr_addr_a", addr_a, e.addr);
                check("wr_data_a", wdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (we_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write_b: got addr 0x%08h data 0x%08h, expected no write", addr_b, wdata_b);
            end else begin
                wr_t e;
                e = q_b.pop_front();
                check("wr_addr_b", addr_b, e.addr);
                check("wr_data_b", wdata_b, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic req_t mk(input int t, input int rd, input int rs1, input int rs2,
                                input int f3, input bit alt, input int imm, input bit last);
        req_t r;
        r.t = 3'(t); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.func3 = 3'(f3); r.alt = alt; r.imm = 13'(imm); r.last = last;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int unsigned pick;
        pick = $urandom_range(0, 11);
        r.t     = (pick < 10) ? 3'(pick % 5) : 3'(5 + (pick % 3));
        r.rd    = 5'($urandom);
        r.rs1   = 5'($urandom);
        r.rs2   = 5'($urandom);
        r.func3 = 3'($urandom);
        r.alt   = 1'($urandom);
        r.imm   = 13'($urandom);
        r.last  = 1'b0;
        return r;
    endfunction

    task automatic send(input req_t r, input logic [31:0] expw, input bit use_exp);
        int unsigned waited;
        wr_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_type  = r.t;  req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2;
        req_func3 = r.func3; req_alt = r.alt; req_imm = r.imm; req_last = r.last;
        while (!ready_a && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready_a) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0, expected 1 within 50 cycles");
            open_m = 1'b0;
            return;
        end
        if (r.t <= 3'd4) begin
            e.data = use_exp ? expw : model_word(r);
            e.addr = BASE_A + 32'(4 * n_a);
            q_a.push_back(e);
            n_a++;
            if (!rst_b && ready_b) begin
                e.addr = BASE_B + 32'(4 * n_b);
                q_b.push_back(e);
                n_b++;
            end
            if (n_a == DEPTH_A) begin
                full_m = 1'b1;
                open_m = 1'b0;
            end
        end else begin
            err_m = 1'b1;
        end
        if (r.last) open_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_last  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_session();
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n_a    = 0;
        n_b    = 0;
        err_m  = 1'b0;
        full_m = 1'b0;
        open_m = 1'b1;
        check("ready_after_start", 32'(ready_a), 32'd1);
        check("busy_after_start", 32'(busy_a), 32'd1);
    endtask

    task automatic end_session(input bit poke_start);
        for (int i = 0; i < 30 && !done_a; i++) begin
            @(posedge clk); #1;
        end
        check("done_pulse", 32'(done_a), 32'd1);
        check("count_end", 32'(count_a), n_a);
        check("full_end", 32'(full_a), 32'(full_m));
        check("err_end", 32'(err_a), 32'(err_m));
        if (poke_start) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_ready", 32'(ready_a), 32'd0);
        check("queue_drained", q_a.size(), 32'd0);
    endtask

    task automatic check_reset_a();
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_addr", addr_a, BASE_A);
        check("rst_wdata", wdata_a, 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
    endtask

    initial begin
        req_t r;
        int unsigned len;

        repeat (3) @(posedge clk);
        #1;
        check_reset_a();
        check("rst_addr_b", addr_b, BASE_B);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single R request: add x3,x1,x2
        start_session();
        send(mk(0, 3, 1, 2, 0, 0, 0, 1), 32'h002081B3, 1);
        check("latency_we", 32'(we_a), 32'd1);
        idle();
        end_session(0);

        // Back-to-back stream; the fourth word also fills DEPTH_A
        start_session();
        send(mk(0, 5, 6, 7, 0, 1, 0, 0), 32'h407302B3, 1);
        send(mk(2, 6, 9, 0, 2, 0, 'h0FFC, 0), 32'hFFC4A303, 1);
        check("b2b_we1", 32'(we_a), 32'd1);
        send(mk(3, 0, 9, 6, 2, 0, 8, 0), 32'h0064A423, 1);
        check("b2b_we2", 32'(we_a), 32'd1);
        send(mk(4, 0, 4, 4, 0, 0, 'h1FF8, 1), 32'hFE420CE3, 1);
        check("b2b_we3", 32'(we_a), 32'd1);
        idle();
        end_session(0);

        // Illegal type between legal requests
        start_session();
        send(mk(0, 1, 2, 3, 4, 0, 0, 0), '0, 0);
        send(mk(6, 7, 7, 7, 7, 1, 'h123, 0), '0, 0);
        send(mk(1, 8, 9, 0, 3, 1, 'h7FF, 0), '0, 0);
        send(mk(3, 0, 10, 11, 1, 0, 'h9A5, 1), '0, 0);
        idle();
        end_session(0);

        // DEPTH limit with valid held high and no last
        start_session();
        for (int i = 0; i < 6 && open_m; i++) begin
            send(mk(1, i + 1, i + 2, 0, 0, 0, i * 3, 0), '0, 0);
        end
        check("ready_drop_full", 32'(ready_a), 32'd0);
        end_session(0);
        idle();

        // start pulsed in LOAD and in DONE is ignored
        start_session();
        send(mk(2, 4, 5, 0, 1, 0, 'h010, 0), '0, 0);
        start     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        send(mk(0, 9, 10, 11, 5, 1, 0, 1), '0, 0);
        idle();
        end_session(1);

        // Reset during LOAD, then a fresh session on both instances
        rst_b = 1'b0;
        @(posedge clk); #1;
        start_session();
        send(mk(0, 1, 1, 1, 0, 0, 0, 0), '0, 0);
        send(mk(1, 2, 2, 0, 0, 0, 'h055, 0), '0, 0);
        rst   = 1'b1;
        rst_b = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_a();
        check("rst_addr_b_mid", addr_b, BASE_B);
        check("rst_count_b_mid", 32'(count_b), 32'd0);
        check("rst_queue_a", q_a.size(), 32'd0);
        rst   = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        start_session();
        send(mk(3, 0, 3, 4, 2, 0, 'h0F0, 0), '0, 0);
        send(mk(4, 0, 5, 6, 1, 0, 'h1002, 1), '0, 0);
        idle();
        end_session(0);
        check("count_b", 32'(count_b), n_b);
        check("queue_b_drained", q_b.size(), 32'd0);
        rst_b = 1'b1;

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            start_session();
            len = $urandom_range(1, 6);
            for (int i = 0; i < int'(len) && open_m; i++) begin
                if ($urandom_range(0, 2) == 0) idle();
                r = rand_req();
                r.last = (i == int'(len) - 1);
                send(r, '0, 0);
            end
            idle();
            end_session(0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_a", q_a.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
